// File: rtl/seg7_dual_digit_controller.sv
// Dual-digit 7-segment sequencer: latches an 8-bit value, time-shares one external
// decoder (high nibble, then low nibble) and rate-limits updates. Option: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_dual_digit_controller #(
  parameter int CLKS_PER_UPDATE = 25000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_Value,
  input  logic       i_Value_Valid,
  output logic       o_Value_Ready,
  input  logic       i_Enable,
  output logic [3:0] o_Dec_Nibble,
  input  logic [6:0] i_Dec_Segments,
  output logic [6:0] o_Segment1,
  output logic [6:0] o_Segment2,
  output logic       o_Busy
);

  localparam int CW = (CLKS_PER_UPDATE > 1) ? $clog2(CLKS_PER_UPDATE) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_UPDATE - 1);

  typedef enum logic [1:0] {S_IDLE, S_DEC_HI, S_DEC_LO, S_WAIT} state_t;

  state_t        r_State;
  state_t        w_Next;
  logic [7:0]    r_Value;
  logic [CW-1:0] r_Count;
  logic [6:0]    r_Seg1;
  logic [6:0]    r_Seg2;
  logic          w_Ready;
  logic          w_Xfer;
  logic [3:0]    w_Nibble;
  logic [6:0]    w_Hi_Seg;

  // Handshake: a value transfers on any rising edge where i_Value_Valid && o_Value_Ready;
  // ready depends only on state, and valid while not ready is simply dropped.
  assign w_Xfer = i_Value_Valid && w_Ready;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_State <= S_IDLE;
    else       r_State <= w_Next;
  end

  always_comb begin
    w_Next = r_State;
    case (r_State)
      S_IDLE:   if (i_Value_Valid) w_Next = S_DEC_HI;
      S_DEC_HI: w_Next = S_DEC_LO;
      S_DEC_LO: w_Next = S_WAIT;
      S_WAIT:   if (r_Count == LAST) w_Next = S_IDLE;
      default:  w_Next = S_IDLE;
    endcase
  end

  always_comb begin
    w_Ready  = 1'b0;
    w_Nibble = 4'h0;
    case (r_State)
      S_IDLE:   w_Ready  = 1'b1;
      S_DEC_HI: w_Nibble = r_Value[7:4];
      S_DEC_LO: w_Nibble = r_Value[3:0];
      default:  w_Nibble = 4'h0;
    endcase
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign w_Hi_Seg = (r_Value[7:4] == 4'h0) ? 7'h7F : i_Dec_Segments;
`else
  assign w_Hi_Seg = i_Dec_Segments;
`endif

  // Each digit register only changes in its own decode slot, so displays stay static otherwise.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Value <= 8'h00;
      r_Count <= '0;
      r_Seg1  <= 7'h7F;
      r_Seg2  <= 7'h7F;
    end else begin
      if (w_Xfer) r_Value <= i_Value;
      case (r_State)
        S_DEC_HI: r_Seg1 <= w_Hi_Seg;
        S_DEC_LO: begin
          r_Seg2  <= i_Dec_Segments;
          r_Count <= '0;
        end
        S_WAIT:   r_Count <= r_Count + 1'b1;
        default:  r_Count <= r_Count;
      endcase
    end
  end

  assign o_Value_Ready = w_Ready;
  assign o_Busy        = !w_Ready;
  assign o_Dec_Nibble  = w_Nibble;
  assign o_Segment1    = i_Enable ? r_Seg1 : 7'h7F;
  assign o_Segment2    = i_Enable ? r_Seg2 : 7'h7F;

endmodule

// File: tb/tb_seg7_dual_digit_controller.sv
// Bench for seg7_dual_digit_controller: reference decoder attached, model tracks
// edges since the last transfer and the expected digit contents.
module tb_seg7_dual_digit_controller;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       i_Rst = 1'b0;
  logic [7:0] i_Value = 8'h00;
  logic       i_Value_Valid = 1'b0;
  logic       i_Enable = 1'b1;
  logic       o_Value_Ready;
  logic [3:0] o_Dec_Nibble;
  logic [6:0] dec_seg;
  logic [6:0] o_Segment1;
  logic [6:0] o_Segment2;
  logic       o_Busy;

  int checks = 0;
  int failures = 0;

  // Model state: edges since last transfer, latched value, expected digit registers.
  int         age = 1000;
  logic [7:0] m_val = 8'h00;
  logic [6:0] m_d1 = 7'h7F;
  logic [6:0] m_d2 = 7'h7F;

  always #5 clk = ~clk;

  seg7_dual_digit_controller #(.CLKS_PER_UPDATE(N)) dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_Value(i_Value), .i_Value_Valid(i_Value_Valid),
    .o_Value_Ready(o_Value_Ready), .i_Enable(i_Enable), .o_Dec_Nibble(o_Dec_Nibble),
    .i_Dec_Segments(dec_seg), .o_Segment1(o_Segment1), .o_Segment2(o_Segment2),
    .o_Busy(o_Busy)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000; 4'h1: s = 7'b1111001; 4'h2: s = 7'b0100100; 4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001; 4'h5: s = 7'b0010010; 4'h6: s = 7'b0000010; 4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000; 4'h9: s = 7'b0010000; 4'hA: s = 7'b0001000; 4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110; 4'hD: s = 7'b0100001; 4'hE: s = 7'b0000110; default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign dec_seg = ref_seg(o_Dec_Nibble);

  function automatic logic [6:0] hi_digit(input logic [7:0] v);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    return (v[7:4] == 4'h0) ? 7'h7F : ref_seg(v[7:4]);
`else
    return ref_seg(v[7:4]);
`endif
  endfunction

  // Expected {ready, busy, nibble, seg1, seg2} from the model.
  function automatic logic [19:0] exp_bundle();
    logic       r;
    logic [3:0] nib;
    r   = (age >= N + 2);
    nib = (age == 0) ? m_val[7:4] : (age == 1) ? m_val[3:0] : 4'h0;
    return {r, !r, nib, i_Enable ? m_d1 : 7'h7F, i_Enable ? m_d2 : 7'h7F};
  endfunction

  function automatic logic [19:0] act_bundle();
    return {o_Value_Ready, o_Busy, o_Dec_Nibble, o_Segment1, o_Segment2};
  endfunction

  task automatic step(input logic v, input logic [7:0] val);
    i_Value_Valid = v;
    i_Value       = val;
    @(posedge clk);
    if (age >= N + 2 && v) begin
      age   = 0;
      m_val = val;
    end else begin
      if (age < 1000) age++;
      if (age == 1) m_d1 = hi_digit(m_val);
      if (age == 2) m_d2 = ref_seg(m_val[3:0]);
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < N + 3 && age < N + 2; i++) step(1'b0, 8'h00);
  endtask

  task automatic model_reset();
    age  = 1000;
    m_d1 = 7'h7F;
    m_d2 = 7'h7F;
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    model_reset();
    #2;
    checks++;
    if (act_bundle() !== {1'b1, 1'b0, 4'h0, 7'h7F, 7'h7F}) begin
      failures++;
      $display("FAIL reset_state: got %h exp %h", act_bundle(), {1'b1, 1'b0, 4'h0, 7'h7F, 7'h7F});
    end
    @(negedge clk);
    i_Rst = 1'b0;
  endtask

  task automatic test_basic();
    int low;
    int edges;
    drain();
    step(1'b1, 8'h3A);
    checks++;
    if (o_Dec_Nibble !== 4'h3) begin
      failures++; $display("FAIL basic_nib_hi: got %h exp 3", o_Dec_Nibble);
    end
    low = 0;
    edges = 0;
    while (o_Value_Ready === 1'b0 && low < 50) begin
      low++;
      step(1'b1, 8'h3A);
      edges++;
      checks++;
      if (act_bundle() !== exp_bundle()) begin
        failures++; $display("FAIL basic_cycle%0d: got %h exp %h", edges, act_bundle(), exp_bundle());
      end
      if (edges == 1) begin
        checks++;
        if (o_Dec_Nibble !== 4'hA || o_Segment1 !== 7'b0110000) begin
          failures++; $display("FAIL basic_edge1: got nib %h seg1 %b exp A 0110000", o_Dec_Nibble, o_Segment1);
        end
      end
      if (edges == 2) begin
        checks++;
        if (o_Segment2 !== 7'b0001000) begin
          failures++; $display("FAIL basic_edge2: got seg2 %b exp 0001000", o_Segment2);
        end
      end
    end
    checks++;
    if (low != N + 2) begin
      failures++; $display("FAIL basic_ready_low: got %0d cycles exp %0d", low, N + 2);
    end
    step(1'b1, 8'h3A);
    edges++;
    checks++;
    if (o_Value_Ready !== 1'b0 || edges != N + 3) begin
      failures++; $display("FAIL basic_spacing: got ready %b after %0d edges exp 0 after %0d", o_Value_Ready, edges, N + 3);
    end
    drain();
  endtask

  task automatic test_stream();
    logic [7:0] v;
    int         accepts;
    accepts = 0;
    for (int i = 0; i < 30; i++) begin
      v = 8'((i % 15 + 1) * 8'h11);
      step(1'b1, v);
      if (age == 0) accepts++;
      checks++;
      if (act_bundle() !== exp_bundle()) begin
        failures++; $display("FAIL stream_cycle%0d: got %h exp %h", i, act_bundle(), exp_bundle());
      end
    end
    checks++;
    if (accepts != 5) begin
      failures++; $display("FAIL stream_accepts: got %0d exp 5", accepts);
    end
    drain();
  endtask

  task automatic test_enable();
    step(1'b1, 8'h3A);
    drain();
    i_Enable = 1'b0;
    #1;
    checks++;
    if (o_Segment1 !== 7'h7F || o_Segment2 !== 7'h7F) begin
      failures++; $display("FAIL enable_blank: got %h %h exp 7f 7f", o_Segment1, o_Segment2);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00);
      checks++;
      if (act_bundle() !== exp_bundle()) begin
        failures++; $display("FAIL enable_hold%0d: got %h exp %h", i, act_bundle(), exp_bundle());
      end
    end
    i_Enable = 1'b1;
    #1;
    checks++;
    if (o_Segment1 !== 7'b0110000 || o_Segment2 !== 7'b0001000 || o_Value_Ready !== 1'b1) begin
      failures++; $display("FAIL enable_restore: got %b %b rdy %b exp 0110000 0001000 1", o_Segment1, o_Segment2, o_Value_Ready);
    end
  endtask

  task automatic test_reset_mid();
    drain();
    step(1'b1, 8'h58);
    step(1'b0, 8'h00);
    #2;
    i_Rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (act_bundle() !== {1'b1, 1'b0, 4'h0, 7'h7F, 7'h7F}) begin
      failures++; $display("FAIL reset_mid: got %h exp %h", act_bundle(), {1'b1, 1'b0, 4'h0, 7'h7F, 7'h7F});
    end
    @(negedge clk);
    i_Rst = 1'b0;
    step(1'b1, 8'h58);
    for (int i = 0; i < N + 2; i++) begin
      step(1'b0, 8'h00);
      checks++;
      if (act_bundle() !== exp_bundle()) begin
        failures++; $display("FAIL reset_mid_cycle%0d: got %h exp %h", i, act_bundle(), exp_bundle());
      end
    end
    checks++;
    if (o_Segment1 !== 7'b0010010 || o_Segment2 !== 7'b0000000 || o_Value_Ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid_redisplay: got %b %b rdy %b exp 0010010 0000000 1", o_Segment1, o_Segment2, o_Value_Ready);
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] exp1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    exp1 = 7'h7F;
`else
    exp1 = 7'b1000000;
`endif
    drain();
    step(1'b1, 8'h05);
    drain();
    checks++;
    if (o_Segment1 !== exp1 || o_Segment2 !== 7'b0010010) begin
      failures++; $display("FAIL leading_zero: got %b %b exp %b 0010010", o_Segment1, o_Segment2, exp1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      i_Enable = ($urandom_range(0, 7) != 0);
      step(($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)));
      checks++;
      if (act_bundle() !== exp_bundle()) begin
        failures++; $display("FAIL random_cycle%0d: got %h exp %h", i, act_bundle(), exp_bundle());
      end
    end
    i_Enable = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_stream();
    test_enable();
    test_reset_mid();
    test_leading_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
